// File: rtl/alu_result_stage.sv
// Registered result/flag stage behind the ALU adder: computes NZCV on the input side,
// buffers through a 2-entry skid (main + skid) with valid/ready handshake and a sticky overflow bit.
module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [3:0]       flags;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Flags packed as {N, Z, C, V}; V is signed overflow of a same-sign addition.
    function automatic logic [3:0] calc_flags(
        input logic [WIDTH-1:0] sum,
        input logic             cout,
        input logic             a_msb,
        input logic             b_msb
    );
        logic n;
        logic z;
        logic v;
        n = sum[WIDTH-1];
        z = (sum == {WIDTH{1'b0}});
        v = (a_msb == b_msb) && (n != a_msb);
        return {n, z, cout, v};
    endfunction

    state_t state_q;
    state_t state_d;
    entry_t main_q;
    entry_t main_d;
    entry_t skid_q;
    entry_t skid_d;
    logic   sticky_q;
    logic   sticky_d;

    logic   in_fire_s;
    logic   out_fire_s;
    entry_t in_entry_s;

    // in_ready comes only from the state register, so out_ready never reaches it combinationally.
    assign in_ready   = (state_q != TWO);
    assign out_valid  = (state_q != EMPTY);
    assign out_result = main_q.result;
    assign out_flags  = main_q.flags;
    assign ovf_sticky = sticky_q;

    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid && out_ready;
    assign in_entry_s = '{result: in_sum, flags: calc_flags(in_sum, in_cout, in_a_msb, in_b_msb)};

    // Next-state and storage steering for the main/skid pair.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire_s) begin
                    main_d  = in_entry_s;
                    state_d = ONE;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                if (in_fire_s && out_fire_s) begin
                    main_d  = in_entry_s;
                    state_d = ONE;
                end else if (in_fire_s) begin
                    skid_d  = in_entry_s;
                    state_d = TWO;
                end else if (out_fire_s) begin
                    state_d = EMPTY;
                end else begin
                    state_d = ONE;
                end
            end
            TWO: begin
                if (out_fire_s) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end else begin
                    state_d = TWO;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Sticky overflow: a new overflowing result beats a simultaneous clear.
    always_comb begin
        sticky_d = sticky_q;
        if (in_fire_s && in_entry_s.flags[0]) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State, data and sticky registers; reset discards all buffered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: flag vector table, scoreboard queue,
// and directed sequences for backpressure, sticky clear race and mid-flight reset.
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_sum;
    logic        in_cout;
    logic        in_a_msb;
    logic        in_b_msb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        ovf_sticky;
    logic        clr_sticky;

    int checks;
    int failures;
    logic [35:0] sb_q[$];

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        a_msb;
        logic        b_msb;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
        logic        exp_sticky;
    } vec_t;

    vec_t vecs[7];

    alu_result_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference flags written as sum-of-products rather than the equality form.
    function automatic logic [3:0] ref_flags(input logic [31:0] s, input logic c, input logic a, input logic b);
        logic v;
        v = (~a & ~b & s[31]) | (a & b & ~s[31]);
        return {s[31], ~|s, c, v};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic sb_step();
        logic [35:0] e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_result", out_result, e[35:4]);
                    chk("sb_flags", {28'd0, out_flags}, {28'd0, e[3:0]});
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({in_sum, ref_flags(in_sum, in_cout, in_a_msb, in_b_msb)});
            end
        end
    endtask

    // Scoreboard at the falling edge, then advance to just after the rising edge.
    task automatic tick();
        @(negedge clk);
        sb_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] s, input logic c, input logic a, input logic b);
        in_valid = 1'b1;
        in_sum   = s;
        in_cout  = c;
        in_a_msb = a;
        in_b_msb = b;
    endtask

    initial begin
        logic [31:0] s;
        checks   = 0;
        failures = 0;
        vecs[0] = '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0110, 1'b0};
        vecs[1] = '{32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 4'b1001, 1'b1};
        vecs[2] = '{32'h0000_0005, 1'b0, 1'b0, 1'b0, 32'h0000_0005, 4'b0000, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b0011, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'b1000, 1'b1};
        vecs[5] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b0100, 1'b1};
        vecs[6] = '{32'h8000_0000, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 4'b1010, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_sum = 32'd0; in_cout = 1'b0;
        in_a_msb = 1'b0; in_b_msb = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", out_result, 32'd0);
        chk("rst_flags", {28'd0, out_flags}, 32'd0);
        chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].sum, vecs[i].cout, vecs[i].a_msb, vecs[i].b_msb);
            tick();
            chk("vec_valid", {31'd0, out_valid}, 32'd1);
            chk("vec_result", out_result, vecs[i].exp_res);
            chk("vec_flags", {28'd0, out_flags}, {28'd0, vecs[i].exp_flags});
            chk("vec_sticky", {31'd0, ovf_sticky}, {31'd0, vecs[i].exp_sticky});
        end
        in_valid = 1'b0;
        tick();
        chk("no_dup_valid", {31'd0, out_valid}, 32'd0);

        clr_sticky = 1'b1;
        tick();
        chk("sticky_clear", {31'd0, ovf_sticky}, 32'd0);
        drive(32'h8000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sticky_race", {31'd0, ovf_sticky}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("sticky_clear2", {31'd0, ovf_sticky}, 32'd0);
        clr_sticky = 1'b0;
        tick();
        chk("sticky_hold0", {31'd0, ovf_sticky}, 32'd0);

        out_ready = 1'b0;
        drive(32'h1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp1_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp1_valid", {31'd0, out_valid}, 32'd1);
        chk("bp1_result", out_result, 32'h1);
        drive(32'h2, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp2_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp2_result", out_result, 32'h1);
        drive(32'h3, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp3_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp3_hold", out_result, 32'h1);
        out_ready = 1'b1;
        tick();
        chk("bp_drain2", out_result, 32'h2);
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_drain3", out_result, 32'h3);
        chk("bp_valid3", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 100; i++) begin
            s = $urandom;
            if (i % 10 == 0) s = 32'd0;
            drive(s, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            tick();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            chk("stream_latency", out_result, s);
        end
        in_valid = 1'b0;
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;

        out_ready = 1'b0;
        drive(32'h8000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h0000_000B, 1'b0, 1'b0, 1'b0);
        tick();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_sticky", {31'd0, ovf_sticky}, 32'd1);
        chk("full_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_result", out_result, 32'd0);
        chk("arst_flags", {28'd0, out_flags}, 32'd0);
        chk("arst_sticky", {31'd0, ovf_sticky}, 32'd0);
        sb_q.delete();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_result", out_result, 32'd0);
        tick();
        chk("post_rst_valid2", {31'd0, out_valid}, 32'd0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
